// File: rtl/ap_ctrl_pkg.sv
// Shared types, default widths and helpers for the ap_ctrl handshake driver.
package ap_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int DFLT_TXN_W = 16;
  localparam int DFLT_CNT_W = 32;
  localparam int DFLT_GAP_W = 8;

  // Working width of lat_calc; callers zero-extend into it and truncate back,
  // which keeps the low CNT_W bits a correct modulo-2^CNT_W difference.
  localparam int LAT_CALC_W = 64;

  // Modular cycle difference; a counter wrap between ts and now is harmless.
  function automatic logic [LAT_CALC_W-1:0] lat_calc(
    input logic [LAT_CALC_W-1:0] now,
    input logic [LAT_CALC_W-1:0] ts
  );
    return now - ts;
  endfunction

endpackage

// File: rtl/ap_ctrl_ts_fifo.sv
// Timestamp FIFO: holds the acceptance cycle of every outstanding transaction.
// A push is taken while full as long as a pop happens in the same cycle.
module ap_ctrl_ts_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Status flags and qualified push/pop strobes.
  always_comb begin
    full    = (count == FULL_CNT);
    empty   = (count == '0);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    head    = mem[rd_ptr];
  end

  // Pointer and occupancy bookkeeping; reset empties the FIFO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents are meaningless while empty so it is not reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ap_ctrl_hs_driver.sv
// Initiator side of the ap_start/ap_ready/ap_done/ap_continue handshake.
// Issues a programmed number of transactions, throttled by the number still
// outstanding, spaces ap_continue by a programmable gap, and reports latency,
// start interval and protocol errors.
module ap_ctrl_hs_driver
  import ap_ctrl_pkg::*;
#(
  parameter int TXN_W = DFLT_TXN_W,
  parameter int CNT_W = DFLT_CNT_W,
  parameter int DEPTH = 4,
  parameter int GAP_W = DFLT_GAP_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_go,
  input  logic [TXN_W-1:0] cfg_num_txn,
  input  logic [GAP_W-1:0] cfg_cont_gap,
  output logic             busy,
  output logic             run_done,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  output logic [TXN_W-1:0] txn_issued,
  output logic [TXN_W-1:0] txn_completed,
  output logic             lat_valid,
  output logic [CNT_W-1:0] last_latency,
  output logic [CNT_W-1:0] max_latency,
  output logic [CNT_W-1:0] last_interval,
  output logic             err_underflow,
  output logic             err_spurious_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] prev_ts;
  logic [TXN_W-1:0] num_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gcnt;
  logic             armed;

  logic             accept;
  logic             comp;
  logic             pop_ok;
  logic             underflow_evt;
  logic             push;
  logic [TXN_W-1:0] issued_next;
  logic [TXN_W-1:0] completed_next;
  logic [CW-1:0]    count_next;
  logic [CNT_W-1:0] lat;
  logic [CNT_W-1:0] ivl;
  logic [GAP_W-1:0] gap_rem;

  logic [CNT_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  ap_ctrl_ts_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CNT_W)
  ) u_ts_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (cnt),
    .pop       (pop_ok),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Handshake events and the values they produce this cycle.
  always_comb begin
    accept         = ap_start & ap_ready;
    comp           = ap_done & ap_continue;
    pop_ok         = comp & ~fifo_empty;
    underflow_evt  = comp & fifo_empty;
    push           = accept & (~fifo_full | pop_ok);
    issued_next    = txn_issued + TXN_W'(push);
    completed_next = txn_completed + TXN_W'(pop_ok);
    count_next     = fifo_count + CW'(push) - CW'(pop_ok);
    lat            = CNT_W'(lat_calc(LAT_CALC_W'(cnt), LAT_CALC_W'(fifo_head)));
    ivl            = CNT_W'(lat_calc(LAT_CALC_W'(cnt), LAT_CALC_W'(prev_ts)));
    gap_rem        = (armed ? gcnt : gap_q) - 1'b1;
  end

  // Free-running cycle counter used as the timestamp base.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt + 1'b1;
  end

  // Run FSM with all handshake, statistics and error outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      busy               <= 1'b0;
      run_done           <= 1'b0;
      ap_start           <= 1'b0;
      ap_continue        <= 1'b0;
      txn_issued         <= '0;
      txn_completed      <= '0;
      lat_valid          <= 1'b0;
      last_latency       <= '0;
      max_latency        <= '0;
      last_interval      <= '0;
      err_underflow      <= 1'b0;
      err_spurious_ready <= 1'b0;
      prev_ts            <= '0;
      num_q              <= '0;
      gap_q              <= '0;
      gcnt               <= '0;
      armed              <= 1'b0;
    end else begin
      lat_valid <= 1'b0;
      run_done  <= 1'b0;
      if (ap_ready && !ap_start) err_spurious_ready <= 1'b1;
      if (underflow_evt)         err_underflow      <= 1'b1;

      case (state)
        IDLE: begin
          if (cfg_go) begin
            num_q              <= cfg_num_txn;
            gap_q              <= cfg_cont_gap;
            txn_issued         <= '0;
            txn_completed      <= '0;
            last_latency       <= '0;
            max_latency        <= '0;
            last_interval      <= '0;
            err_underflow      <= 1'b0;
            err_spurious_ready <= 1'b0;
            armed              <= 1'b0;
            if (cfg_num_txn != '0) begin
              state       <= RUN;
              busy        <= 1'b1;
              ap_start    <= 1'b1;
              ap_continue <= (cfg_cont_gap == '0);
            end else begin
              state    <= FINISH;
              run_done <= 1'b1;
            end
          end
        end

        RUN, DRAIN: begin
          if (push) begin
            txn_issued <= issued_next;
            prev_ts    <= cnt;
            if (txn_issued != '0) last_interval <= ivl;
          end
          if (pop_ok) begin
            txn_completed <= completed_next;
            last_latency  <= lat;
            lat_valid     <= 1'b1;
            if (lat > max_latency) max_latency <= lat;
          end

          // ap_continue: held high with no gap, otherwise a one-cycle pulse
          // after gap_q idle cycles of ap_done.
          if (gap_q == '0) begin
            ap_continue <= 1'b1;
          end else begin
            ap_continue <= 1'b0;
            if (ap_done && !ap_continue) begin
              if (gap_rem == '0) begin
                ap_continue <= 1'b1;
                armed       <= 1'b0;
              end else begin
                gcnt  <= gap_rem;
                armed <= 1'b1;
              end
            end
          end

          if (state == RUN) begin
            if (push && (issued_next == num_q)) begin
              state    <= DRAIN;
              ap_start <= 1'b0;
            end else begin
              ap_start <= (issued_next < num_q) && (count_next < FULL_CNT);
            end
          end else begin
            ap_start <= 1'b0;
            if (pop_ok && (completed_next == num_q)) begin
              state       <= FINISH;
              busy        <= 1'b0;
              run_done    <= 1'b1;
              ap_continue <= 1'b0;
              armed       <= 1'b0;
            end
          end
        end

        FINISH: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ap_ctrl_hs_driver.sv
// Directed bench for ap_ctrl_hs_driver. The kernel's ap_ready follows
// ap_start (enable-gated, with a force for protocol-error injection);
// ap_done is driven step by step. CNT_W is reduced so the cycle counter
// wraps inside the final run.
module tb_ap_ctrl_hs_driver;

  localparam int TXN_W = 16;
  localparam int CNT_W = 6;
  localparam int DEPTH = 4;
  localparam int GAP_W = 8;

  logic             clock;
  logic             reset;
  logic             cfg_go;
  logic [TXN_W-1:0] cfg_num_txn;
  logic [GAP_W-1:0] cfg_cont_gap;
  logic             busy;
  logic             run_done;
  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_continue;
  logic [TXN_W-1:0] txn_issued;
  logic [TXN_W-1:0] txn_completed;
  logic             lat_valid;
  logic [CNT_W-1:0] last_latency;
  logic [CNT_W-1:0] max_latency;
  logic [CNT_W-1:0] last_interval;
  logic             err_underflow;
  logic             err_spurious_ready;

  logic rdy_en;
  logic rdy_force;

  int n_cmp;
  int n_err;

  assign ap_ready = (ap_start & rdy_en) | rdy_force;

  ap_ctrl_hs_driver #(
    .TXN_W (TXN_W),
    .CNT_W (CNT_W),
    .DEPTH (DEPTH),
    .GAP_W (GAP_W)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .cfg_go             (cfg_go),
    .cfg_num_txn        (cfg_num_txn),
    .cfg_cont_gap       (cfg_cont_gap),
    .busy               (busy),
    .run_done           (run_done),
    .ap_start           (ap_start),
    .ap_ready           (ap_ready),
    .ap_done            (ap_done),
    .ap_continue        (ap_continue),
    .txn_issued         (txn_issued),
    .txn_completed      (txn_completed),
    .lat_valid          (lat_valid),
    .last_latency       (last_latency),
    .max_latency        (max_latency),
    .last_interval      (last_interval),
    .err_underflow      (err_underflow),
    .err_spurious_ready (err_spurious_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    reset        = 1'b1;
    cfg_go       = 1'b0;
    cfg_num_txn  = '0;
    cfg_cont_gap = '0;
    ap_done      = 1'b0;
    rdy_en       = 1'b1;
    rdy_force    = 1'b0;
    ticks(2);

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_start", ap_start, 0);
    chk("rst_cont", ap_continue, 0);
    chk("rst_issued", txn_issued, 0);
    chk("rst_maxlat", max_latency, 0);
    reset = 1'b0;
    tick();

    // Run A: num=3, gap=0, done 5 cycles after each accept
    cfg_num_txn = 3; cfg_cont_gap = 0; cfg_go = 1'b1;
    tick(); cfg_go = 1'b0;                       // C1
    chk("a_busy", busy, 1);
    chk("a_start", ap_start, 1);
    chk("a_cont", ap_continue, 1);
    ticks(3);                                    // C4
    chk("a_issued", txn_issued, 3);
    chk("a_start_drop", ap_start, 0);
    chk("a_interval", last_interval, 1);
    ticks(2); ap_done = 1'b1;                    // C6
    tick();                                      // C7
    chk("a_lv1", lat_valid, 1);
    chk("a_lat1", last_latency, 5);
    chk("a_cmp1", txn_completed, 1);
    tick();                                      // C8
    chk("a_lat2", last_latency, 5);
    chk("a_cmp2", txn_completed, 2);
    tick();                                      // C9
    chk("a_lv3", lat_valid, 1);
    chk("a_lat3", last_latency, 5);
    chk("a_cmp3", txn_completed, 3);
    chk("a_done", run_done, 1);
    chk("a_busy_end", busy, 0);
    chk("a_max", max_latency, 5);
    ap_done = 1'b0;
    tick();                                      // C10
    chk("a_done_once", run_done, 0);

    // Run B: num=6 with DEPTH=4 outstanding, done 10 cycles after accept
    cfg_num_txn = 6; cfg_cont_gap = 0; cfg_go = 1'b1;
    tick(); cfg_go = 1'b0;                       // C1
    ticks(4);                                    // C5
    chk("b_start_full", ap_start, 0);
    chk("b_issued4", txn_issued, 4);
    ticks(6);                                    // C11
    chk("b_start_wait", ap_start, 0);
    ap_done = 1'b1;
    tick();                                      // C12
    chk("b_start_resume", ap_start, 1);
    chk("b_cmp1", txn_completed, 1);
    chk("b_lat1", last_latency, 10);
    tick();                                      // C13
    chk("b_interval", last_interval, 8);
    tick();                                      // C14
    chk("b_issued6", txn_issued, 6);
    chk("b_start_end", ap_start, 0);
    chk("b_cmp3", txn_completed, 3);
    tick(); ap_done = 1'b0;                      // C15
    chk("b_cmp4", txn_completed, 4);
    ticks(7); ap_done = 1'b1;                    // C22
    tick();                                      // C23
    chk("b_lat5", last_latency, 10);
    tick();                                      // C24
    chk("b_done", run_done, 1);
    chk("b_cmp6", txn_completed, 6);
    chk("b_issued_end", txn_issued, 6);
    chk("b_max", max_latency, 10);
    chk("b_uflow", err_underflow, 0);
    chk("b_spur", err_spurious_ready, 0);
    ap_done = 1'b0;
    tick();

    // Run C: gap=3, single transaction, kernel holds ap_done
    cfg_num_txn = 1; cfg_cont_gap = 3; cfg_go = 1'b1;
    tick(); cfg_go = 1'b0;                       // C1
    chk("c_cont_init", ap_continue, 0);
    ticks(2); ap_done = 1'b1;                    // C3
    ticks(2);                                    // C5
    chk("c_cont_wait", ap_continue, 0);
    tick();                                      // C6
    chk("c_cont_rise", ap_continue, 1);
    tick();                                      // C7
    chk("c_lv", lat_valid, 1);
    chk("c_lat", last_latency, 5);
    chk("c_done", run_done, 1);
    chk("c_cont_fall", ap_continue, 0);
    ap_done = 1'b0;
    tick();

    // Run D: num=0
    cfg_num_txn = 0; cfg_cont_gap = 0; cfg_go = 1'b1;
    tick(); cfg_go = 1'b0;                       // C1
    chk("d_busy", busy, 0);
    chk("d_done", run_done, 1);
    chk("d_start", ap_start, 0);
    tick();
    chk("d_done_off", run_done, 0);
    chk("d_start2", ap_start, 0);

    // Run E: protocol errors
    cfg_num_txn = 1; cfg_cont_gap = 0; rdy_en = 1'b0; cfg_go = 1'b1;
    tick(); cfg_go = 1'b0; ap_done = 1'b1;       // C1
    tick();                                      // C2
    chk("e_uflow", err_underflow, 1);
    chk("e_cmp0", txn_completed, 0);
    chk("e_lv0", lat_valid, 0);
    ap_done = 1'b0; rdy_en = 1'b1;
    tick();                                      // C3
    chk("e_issued", txn_issued, 1);
    ap_done = 1'b1;
    tick();                                      // C4
    chk("e_done", run_done, 1);
    chk("e_lat", last_latency, 1);
    ap_done = 1'b0;
    tick(); rdy_force = 1'b1;                    // C5
    tick(); rdy_force = 1'b0;                    // C6
    chk("e_spur", err_spurious_ready, 1);
    chk("e_uflow_sticky", err_underflow, 1);
    chk("e_issued_keep", txn_issued, 1);
    chk("e_cmp_keep", txn_completed, 1);
    cfg_num_txn = 0; cfg_go = 1'b1;
    tick(); cfg_go = 1'b0;
    chk("e_spur_clr", err_spurious_ready, 0);
    chk("e_uflow_clr", err_underflow, 0);
    tick();

    // Run F: reset mid-DRAIN with 2 outstanding, then a wrapping run
    cfg_num_txn = 2; cfg_cont_gap = 0; cfg_go = 1'b1;
    tick(); cfg_go = 1'b0;                       // C1
    ticks(2);                                    // C3
    chk("f_busy", busy, 1);
    chk("f_issued", txn_issued, 2);
    reset = 1'b1;
    #1;
    chk("f_rst_busy", busy, 0);
    chk("f_rst_start", ap_start, 0);
    chk("f_rst_cont", ap_continue, 0);
    chk("f_rst_issued", txn_issued, 0);
    chk("f_rst_ivl", last_interval, 0);
    chk("f_rst_max", max_latency, 0);
    tick();
    reset = 1'b0;                                // cycle counter = 0
    cfg_num_txn = 1;
    ticks(59);                                   // counter = 59
    cfg_go = 1'b1;
    tick(); cfg_go = 1'b0;                       // counter = 60, accept
    chk("f_start", ap_start, 1);
    ticks(5); ap_done = 1'b1;                    // counter = 1 (wrapped)
    tick();
    chk("f_lv", lat_valid, 1);
    chk("f_lat_wrap", last_latency, 5);
    chk("f_max", max_latency, 5);
    chk("f_done", run_done, 1);
    ap_done = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ap_ctrl_hs_driver.md
Name: ap_ctrl_hs_driver

Overview:
- Initiator end of the HLS block-level control handshake (ap_start/ap_ready/ap_done/ap_continue): drives a kernel through a programmed number of transactions instead of passively observing it.
- Throttles itself by outstanding-transaction depth.
- Inserts a programmable ap_continue back-pressure gap.
- Reports per-transaction latency, start interval and protocol errors.
- Sits in the simulation/bring-up harness beside the dataflow monitors; synthesizable so it can also drive kernels on-board.

Parameters:
- TXN_W, 16, width of transaction count and counters.
- CNT_W, 32, width of free-running cycle counter and latency/interval results.
- DEPTH, 4, maximum outstanding transactions (accepted, not yet completed); power of 2, >=2.
- GAP_W, 8, width of the ap_continue gap setting.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cfg_go  in  1  one-cycle pulse; starts a run; ignored while busy=1.
- cfg_num_txn  in  TXN_W  transactions to issue; sampled on cfg_go.
- cfg_cont_gap  in  GAP_W  idle cycles before asserting ap_continue after ap_done; sampled on cfg_go.
- busy  out  1  high from the cycle after accepted cfg_go until run_done.
- run_done  out  1  one-cycle pulse when the run completes.
- ap_start  out  1  to kernel.
- ap_ready  in  1  from kernel.
- ap_done  in  1  from kernel; held until ap_continue.
- ap_continue  out  1  to kernel.
- txn_issued  out  TXN_W  accepted starts this run.
- txn_completed  out  TXN_W  completed transactions this run.
- lat_valid  out  1  one-cycle pulse with each completion.
- last_latency  out  CNT_W  cycles from acceptance to completion of the completing transaction.
- max_latency  out  CNT_W  maximum latency this run.
- last_interval  out  CNT_W  cycles between the last two accepted starts.
- err_underflow  out  1  sticky: completion with no outstanding transaction.
- err_spurious_ready  out  1  sticky: ap_ready seen while ap_start=0.

Behaviour:
- Reset:
  - All outputs 0; state IDLE; timestamp FIFO emptied; cycle counter 0.
  - Reset mid-run aborts immediately with no run_done pulse.
- Cycle counter:
  - Free-running from reset release.
  - Wraps modulo 2^CNT_W; latency is computed modulo 2^CNT_W, so a wrap gives the correct value.
- States and transitions:
  - IDLE -> RUN on cfg_go with cfg_num_txn>0. This clears counters, max_latency and sticky errors.
  - IDLE -> FINISH on cfg_go with cfg_num_txn=0.
  - RUN -> DRAIN on the cycle of the final accept handshake.
  - DRAIN -> FINISH on the cycle txn_completed reaches cfg_num_txn.
  - FINISH -> IDLE after one cycle; run_done=1 during FINISH; busy=0 in IDLE and FINISH.
- ap_start (registered):
  - High in RUN while FIFO not full and txn_issued < num.
  - Accept = ap_start & ap_ready. An accept pushes the cycle counter into the FIFO and increments txn_issued.
  - ap_start drops the cycle after the accept that makes txn_issued=num or fills the FIFO.
  - It reasserts the cycle after a pop frees space.
- Interval:
  - On each accept after the first in a run, last_interval = now − previous accept time.
  - The first accept leaves last_interval at 0.
- ap_continue:
  - If gap=0: ap_continue=1 throughout RUN/DRAIN.
  - Else: gap counter loads on the first cycle ap_done=1 with ap_continue=0, and decrements while ap_done=1.
  - ap_continue=1 for one cycle when the counter reaches 0, then the counter rearms.
- Completion = ap_done & ap_continue:
  - Pops the FIFO, increments txn_completed, pulses lat_valid.
  - last_latency = now − popped timestamp.
  - max_latency updates if last_latency is larger.
- Simultaneous accept and completion in one cycle: push and pop both occur; occupancy is unchanged. A full FIFO with a pop in the same cycle still accepts.
- Errors:
  - Completion with FIFO empty: set err_underflow; no pop; no counter change.
  - ap_ready=1 with ap_start=0: set err_spurious_ready.
  - Both flags are sticky until the next accepted cfg_go or reset.
- Counters txn_issued and txn_completed never exceed cfg_num_txn.

Decomposition:
- Package ap_ctrl_pkg holds:
  - state enum {IDLE, RUN, DRAIN, FINISH};
  - default widths CNT_W/TXN_W/GAP_W;
  - function lat_calc(now, ts) returning the modular difference.
- Sub-module ap_ctrl_ts_fifo: DEPTH×CNT_W synchronous FIFO, push/pop/full/empty, same-cycle push+pop when full allowed.

Test Plan:
- num=3, gap=0, kernel ready the same cycle as start, done 5 cycles after accept -> 3 accepts on consecutive cycles, last_interval=1, three lat_valid pulses each last_latency=5, run_done once, txn_completed=3.
- num=6, DEPTH=4, kernel never asserts done until 10 cycles -> ap_start drops after 4th accept, resumes 1 cycle after first completion, txn_issued=6 at end, no errors.
- gap=3, single transaction, kernel holds ap_done -> ap_continue rises exactly 3 cycles after ap_done first seen; latency includes gap.
- num=0 cfg_go -> busy stays 0, run_done pulses the next cycle, ap_start never asserts.
- Inject ap_done with no outstanding transaction and ap_ready with ap_start=0 -> both sticky errors set; counters unchanged; cleared by next cfg_go.
- Assert reset mid-DRAIN with 2 outstanding -> all outputs 0 asynchronously, FIFO empty; subsequent num=1 run reports correct latency.
